// File: rtl/mat_inv_gj_if.sv
// mat_inv_gj_if
//   Bus bundle for the Gauss-Jordan matrix inverter.
//   i_start    : start request (master -> slave)
//   i_mat      : row-major input matrix, element (r,c) at [(r*ORDER+c)*WIDTH +: WIDTH]
//   o_mat      : row-major inverse, held until the next completion
//   o_busy     : high from start acceptance through the o_done cycle
//   o_done     : one-cycle completion pulse
//   o_singular : pivot fell below threshold (valid with o_done)
//   o_overflow : some saturation happened (valid with o_done)
interface mat_inv_gj_if #(
   parameter int ORDER = 3,
   parameter int WIDTH = 16
);
   logic                         i_start;
   logic [ORDER*ORDER*WIDTH-1:0] i_mat;
   logic [ORDER*ORDER*WIDTH-1:0] o_mat;
   logic                         o_busy;
   logic                         o_done;
   logic                         o_singular;
   logic                         o_overflow;

   modport master (output i_start, i_mat,
                   input  o_mat, o_busy, o_done, o_singular, o_overflow);
   modport slave  (input  i_start, i_mat,
                   output o_mat, o_busy, o_done, o_singular, o_overflow);
endinterface

// File: rtl/mat_inv_gj.sv
// mat_inv_gj
//   Signed fixed-point NxN matrix inverter, Gauss-Jordan with partial pivoting.
//   One inversion in flight; start requests while busy are dropped.
//   Ports:
//     i_clk : rising-edge clock
//     i_rst : asynchronous active-high reset (aborts any run, no o_done)
//     bus   : mat_inv_gj_if slave (start/matrix in, inverse/handshake/flags out)
module mat_inv_gj #(
   parameter int ORDER    = 3,
   parameter int WIDTH    = 16,
   parameter int QBITS    = 8,
   parameter int SING_EPS = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   mat_inv_gj_if.slave bus
);
   localparam int DIV_CYCLES = WIDTH + QBITS;
   localparam int IW = (ORDER > 1) ? $clog2(ORDER) : 1;
   localparam int CW = $clog2(DIV_CYCLES + 1);
   localparam int PW = 2 * WIDTH;
   localparam int EW = 2 * WIDTH + 1;

   localparam logic [IW-1:0]         LAST     = IW'(ORDER - 1);
   localparam logic [CW-1:0]         DIV_LAST = CW'(DIV_CYCLES - 1);
   localparam logic [DIV_CYCLES-1:0] DIVIDEND = DIV_CYCLES'(1) << (2 * QBITS);
   localparam logic [DIV_CYCLES-1:0] QPOS_MAX = DIV_CYCLES'((1 << (WIDTH - 1)) - 1);
   localparam logic [DIV_CYCLES-1:0] QNEG_MAX = DIV_CYCLES'(1 << (WIDTH - 1));
   localparam logic [WIDTH:0]        EPS      = (WIDTH + 1)'(SING_EPS);
   localparam logic signed [WIDTH-1:0] ONE    = WIDTH'(1 << QBITS);
   localparam logic signed [WIDTH-1:0] SMAXW  = {1'b0, {(WIDTH - 1){1'b1}}};
   localparam logic signed [WIDTH-1:0] SMINW  = {1'b1, {(WIDTH - 1){1'b0}}};
   localparam logic signed [EW-1:0]    SMAX   = {{(WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
   localparam logic signed [EW-1:0]    SMIN   = {{(WIDTH + 2){1'b1}}, {(WIDTH - 1){1'b0}}};

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SEARCH = 3'd1;
   localparam logic [2:0] S_SWAP   = 3'd2;
   localparam logic [2:0] S_RECIP  = 3'd3;
   localparam logic [2:0] S_NORM   = 3'd4;
   localparam logic [2:0] S_ELIM   = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;

   function automatic logic [WIDTH:0] abs_w(input logic signed [WIDTH-1:0] x);
      logic signed [WIDTH:0] e;
      e = {x[WIDTH-1], x};
      return x[WIDTH-1] ? -e : e;
   endfunction

   function automatic logic signed [WIDTH-1:0] sat(input logic signed [EW-1:0] x);
      if (x > SMAX) return SMAXW;
      else if (x < SMIN) return SMINW;
      else return x[WIDTH-1:0];
   endfunction

   function automatic logic is_sat(input logic signed [EW-1:0] x);
      return (x > SMAX) || (x < SMIN);
   endfunction

   // (a*b) >>> QBITS, widened so later subtraction cannot wrap
   function automatic logic signed [EW-1:0] mul_q(input logic signed [WIDTH-1:0] a,
                                                  input logic signed [WIDTH-1:0] b);
      logic signed [PW-1:0] p;
      p = PW'(a) * PW'(b);
      return EW'(p >>> QBITS);
   endfunction

   logic [2:0]              state_reg;
   logic signed [WIDTH-1:0] a_reg [ORDER][ORDER];
   logic signed [WIDTH-1:0] b_reg [ORDER][ORDER];
   logic [IW-1:0]           k_reg, r_reg, piv_reg;
   logic [WIDTH:0]          max_reg, den_reg, rem_reg;
   logic                    piv_neg_reg, ovf_reg;
   logic [DIV_CYCLES-1:0]   dvd_reg, quo_reg;
   logic [CW-1:0]           cnt_reg;

   // pivot search: first strict maximum wins, so ties keep the lower row
   logic [WIDTH:0] cand, max_next;
   logic           take;
   assign cand     = abs_w(a_reg[r_reg][k_reg]);
   assign take     = (r_reg == k_reg) || (cand > max_reg);
   assign max_next = take ? cand : max_reg;

   // restoring divider step on the magnitude of the pivot
   logic [WIDTH+1:0] rem_sh;
   logic             q_bit;
   logic [WIDTH:0]   rem_next;
   assign rem_sh   = {rem_reg, dvd_reg[DIV_CYCLES-1]};
   assign q_bit    = rem_sh >= {1'b0, den_reg};
   assign rem_next = q_bit ? (WIDTH + 1)'(rem_sh - {1'b0, den_reg}) : (WIDTH + 1)'(rem_sh);

   // sign restore + saturation; a negative quotient of exactly 2^(WIDTH-1) still fits
   logic signed [WIDTH-1:0] recip;
   logic                    recip_ovf;
   always_comb begin
      recip     = '0;
      recip_ovf = 1'b0;
      if (!piv_neg_reg) begin
         if (quo_reg > QPOS_MAX) begin
            recip     = SMAXW;
            recip_ovf = 1'b1;
         end else begin
            recip = $signed(WIDTH'(quo_reg));
         end
      end else begin
         if (quo_reg > QNEG_MAX) begin
            recip     = SMINW;
            recip_ovf = 1'b1;
         end else begin
            recip = -$signed(WIDTH'(quo_reg));
         end
      end
   end

   logic signed [EW-1:0]    norm_a_x [ORDER], norm_b_x [ORDER], elim_a_x [ORDER], elim_b_x [ORDER];
   logic signed [WIDTH-1:0] norm_a [ORDER], norm_b [ORDER], elim_a [ORDER], elim_b [ORDER];
   logic [ORDER-1:0]        norm_ovf_a, norm_ovf_b, elim_ovf_a, elim_ovf_b;

   for (genvar gi = 0; gi < ORDER; gi++) begin : g_col
      assign norm_a_x[gi]   = mul_q(a_reg[k_reg][gi], recip);
      assign norm_b_x[gi]   = mul_q(b_reg[k_reg][gi], recip);
      assign elim_a_x[gi]   = EW'(a_reg[r_reg][gi]) - mul_q(a_reg[r_reg][k_reg], a_reg[k_reg][gi]);
      assign elim_b_x[gi]   = EW'(b_reg[r_reg][gi]) - mul_q(a_reg[r_reg][k_reg], b_reg[k_reg][gi]);
      assign norm_a[gi]     = sat(norm_a_x[gi]);
      assign norm_b[gi]     = sat(norm_b_x[gi]);
      assign elim_a[gi]     = sat(elim_a_x[gi]);
      assign elim_b[gi]     = sat(elim_b_x[gi]);
      assign norm_ovf_a[gi] = is_sat(norm_a_x[gi]);
      assign norm_ovf_b[gi] = is_sat(norm_b_x[gi]);
      assign elim_ovf_a[gi] = is_sat(elim_a_x[gi]);
      assign elim_ovf_b[gi] = is_sat(elim_b_x[gi]);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg      <= S_IDLE;
         k_reg          <= '0;
         r_reg          <= '0;
         piv_reg        <= '0;
         max_reg        <= '0;
         den_reg        <= '0;
         rem_reg        <= '0;
         piv_neg_reg    <= 1'b0;
         ovf_reg        <= 1'b0;
         dvd_reg        <= '0;
         quo_reg        <= '0;
         cnt_reg        <= '0;
         for (int r = 0; r < ORDER; r++)
            for (int c = 0; c < ORDER; c++) begin
               a_reg[r][c] <= '0;
               b_reg[r][c] <= '0;
            end
         bus.o_mat      <= '0;
         bus.o_busy     <= 1'b0;
         bus.o_done     <= 1'b0;
         bus.o_singular <= 1'b0;
         bus.o_overflow <= 1'b0;
      end else begin
         bus.o_done <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (bus.i_start) begin
                  for (int r = 0; r < ORDER; r++)
                     for (int c = 0; c < ORDER; c++) begin
                        a_reg[r][c] <= bus.i_mat[(r*ORDER+c)*WIDTH +: WIDTH];
                        b_reg[r][c] <= (r == c) ? ONE : '0;
                     end
                  k_reg      <= '0;
                  r_reg      <= '0;
                  ovf_reg    <= 1'b0;
                  bus.o_busy <= 1'b1;
                  state_reg  <= S_SEARCH;
               end
            end
            S_SEARCH: begin
               max_reg <= max_next;
               if (take) begin
                  piv_reg     <= r_reg;
                  piv_neg_reg <= a_reg[r_reg][k_reg][WIDTH-1];
               end
               if (r_reg == LAST) begin
                  if (max_next <= EPS) begin
                     bus.o_mat      <= '0;
                     bus.o_singular <= 1'b1;
                     bus.o_overflow <= ovf_reg;
                     bus.o_done     <= 1'b1;
                     state_reg      <= S_DONE;
                  end else begin
                     state_reg <= S_SWAP;
                  end
               end else begin
                  r_reg <= r_reg + 1'b1;
               end
            end
            S_SWAP: begin
               for (int c = 0; c < ORDER; c++) begin
                  a_reg[k_reg][c]   <= a_reg[piv_reg][c];
                  a_reg[piv_reg][c] <= a_reg[k_reg][c];
                  b_reg[k_reg][c]   <= b_reg[piv_reg][c];
                  b_reg[piv_reg][c] <= b_reg[k_reg][c];
               end
               den_reg   <= max_reg;
               rem_reg   <= '0;
               quo_reg   <= '0;
               dvd_reg   <= DIVIDEND;
               cnt_reg   <= '0;
               state_reg <= S_RECIP;
            end
            S_RECIP: begin
               rem_reg <= rem_next;
               quo_reg <= {quo_reg[DIV_CYCLES-2:0], q_bit};
               dvd_reg <= dvd_reg << 1;
               if (cnt_reg == DIV_LAST) state_reg <= S_NORM;
               else cnt_reg <= cnt_reg + 1'b1;
            end
            S_NORM: begin
               for (int c = 0; c < ORDER; c++) begin
                  a_reg[k_reg][c] <= norm_a[c];
                  b_reg[k_reg][c] <= norm_b[c];
               end
               ovf_reg   <= ovf_reg | recip_ovf | (|norm_ovf_a) | (|norm_ovf_b);
               r_reg     <= '0;
               state_reg <= S_ELIM;
            end
            S_ELIM: begin
               if (r_reg != k_reg) begin
                  for (int c = 0; c < ORDER; c++) begin
                     a_reg[r_reg][c] <= elim_a[c];
                     b_reg[r_reg][c] <= elim_b[c];
                  end
                  ovf_reg <= ovf_reg | (|elim_ovf_a) | (|elim_ovf_b);
               end
               if (r_reg == LAST) begin
                  if (k_reg == LAST) begin
                     // last row is the pivot row here, so B is already final
                     for (int r = 0; r < ORDER; r++)
                        for (int c = 0; c < ORDER; c++)
                           bus.o_mat[(r*ORDER+c)*WIDTH +: WIDTH] <= b_reg[r][c];
                     bus.o_singular <= 1'b0;
                     bus.o_overflow <= ovf_reg;
                     bus.o_done     <= 1'b1;
                     state_reg      <= S_DONE;
                  end else begin
                     k_reg     <= k_reg + 1'b1;
                     r_reg     <= k_reg + 1'b1;
                     state_reg <= S_SEARCH;
                  end
               end else begin
                  r_reg <= r_reg + 1'b1;
               end
            end
            S_DONE: begin
               bus.o_busy <= 1'b0;
               state_reg  <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end
endmodule
